// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared defaults and direction encodings for the T-cell modulo counter
package tff_pkg;

    localparam int   DEFAULT_WIDTH   = 4;
    localparam int   DEFAULT_MODULUS = 10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop cell with asynchronous active-low reset
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - modulo-N up/down counter built from T cells with load, tc and wrap pulse
// Optional macro TFF_MOD_COUNTER_SATURATE_EN: saturate at the terminal states instead of wrapping.
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] t;
    logic             at_last;
    logic             at_zero;
    logic             tc_int;
    logic             wrap_d;
    logic             wrap_q;

    // target is the desired next count; the cells only ever see its XOR with the present count
    always_comb begin
        at_last = (cnt == LAST);
        at_zero = (cnt == '0);
        tc_int  = en & ~load & (((up == DIR_UP) & at_last) | ((up == DIR_DOWN) & at_zero));
        target  = cnt;
        if (load) begin
            target = (din <= LAST) ? din : '0;
        end else if (en) begin
            if (up == DIR_UP) begin
`ifdef TFF_MOD_COUNTER_SATURATE_EN
                target = at_last ? LAST : cnt + WIDTH'(1);
`else
                target = at_last ? '0 : cnt + WIDTH'(1);
`endif
            end else begin
`ifdef TFF_MOD_COUNTER_SATURATE_EN
                target = at_zero ? '0 : cnt - WIDTH'(1);
`else
                target = at_zero ? LAST : cnt - WIDTH'(1);
`endif
            end
        end
        t = cnt ^ target;
    end

`ifdef TFF_MOD_COUNTER_SATURATE_EN
    assign wrap_d = 1'b0;
`else
    assign wrap_d = tc_int;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t[i]),
            .q     (cnt[i])
        );
    end

    assign q    = cnt;
    assign tc   = tc_int;
    assign wrap = wrap_q;

endmodule
